// File: rtl/ps2_keyboard_rx_if.sv
// Bus between the PS/2 keyboard pins, the core's ack strobe and the status word.
// master: the side driving the pins and ack; slave: the receiver.
interface ps2_keyboard_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ack;
  logic [31:0] keyboard_data;

  modport master (
    output ps2_clk,
    output ps2_data,
    output ack,
    input  keyboard_data
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    input  ack,
    output keyboard_data
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises frames, decodes E0/F0 prefixes, keeps a
// held-key bitmap for the game keys and presents a 32-bit status word.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input logic             clk,
  input logic             reset,
  ps2_keyboard_rx_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          fall_q, bit_q;
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d, cnt_q, cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d, new_q, new_d, err_q, err_d;
  logic [4:0]    held_q, held_d;
  logic          parity_ok;

  // Two-stage synchronisers plus a registered falling-edge strobe; sync regs idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s1   <= bus.ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= bus.ps2_data;
      data_s2  <= data_s1;
      fall_q   <= clk_prev & ~clk_s2;
      bit_q    <= data_s2;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  // Capture the parity bit so it can be checked with the data byte at STOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (fall_q && state_q == StParity) begin
      par_q <= bit_q;
    end
  end
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM, timeout, prefix decode, held bitmap and status-word next state
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    to_d       = to_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    new_d      = new_q;
    err_d      = err_q;
    held_d     = held_q;
    cnt_d      = cnt_q;

    // ack is applied first so a same-cycle event or error overrides it
    if (bus.ack) begin
      new_d = 1'b0;
      err_d = 1'b0;
    end

    if (state_q == StIdle || fall_q) begin
      to_d = '0;
    end else begin
      to_d = to_q + TW'(1);
    end

    if (fall_q) begin
      case (state_q)
        StIdle: begin
          if (!bit_q) begin
            state_d = StData;
            idx_d   = 3'd0;
          end
        end
        StData: begin
          shift_d = {bit_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StParity;
        end
        StParity: state_d = StStop;
        StStop: begin
          state_d = StIdle;
          if (!bit_q || !parity_ok) begin
            err_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else begin
            code_d     = shift_q;
            ext_d      = ext_pend_q;
            brk_d      = brk_pend_q;
            new_d      = 1'b1;
            cnt_d      = cnt_q + 8'd1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            case ({ext_pend_q, shift_q})
              9'h175:  held_d[0] = ~brk_pend_q;
              9'h172:  held_d[1] = ~brk_pend_q;
              9'h16B:  held_d[2] = ~brk_pend_q;
              9'h174:  held_d[3] = ~brk_pend_q;
              9'h029:  held_d[4] = ~brk_pend_q;
              default: ;
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_q == TW'(TIMEOUT_CYCLES)) begin
      // Stalled partial frame: resynchronise on the next start bit
      state_d    = StIdle;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      shift_q    <= '0;
      to_q       <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      new_q      <= 1'b0;
      err_q      <= 1'b0;
      held_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      to_q       <= to_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      new_q      <= new_d;
      err_q      <= err_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.keyboard_data = {cnt_q, 7'b0, held_q, err_q, new_q, brk_q, ext_q, code_q};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; PS/2 timing is scaled down to a few clk cycles per bit.
module tb_ps2_keyboard_rx;

  localparam int unsigned TIMEOUT = 200;

  logic       clk;
  logic       reset;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         half = 20;
  logic [7:0] base;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par,
                                        input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Send the first n bits of a frame, bit 0 first; ps2_clk ends high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.ps2_data = bits[i];
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] bits);
    send_bits(bits, 11);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(frame(d, 1'b0, 1'b1));
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk) bus.ack = 1'b1;
    @(negedge clk) bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_held: got %h want %h", bus.keyboard_data, 32'h0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_released: got %h want %h", bus.keyboard_data, 32'h0);
    end
  endtask

  // Also checks latency: update lands on the 4th clk edge after the stop-bit fall
  task automatic test_make_code();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL make_early: got %h want %h", bus.keyboard_data, 32'h0);
    end
    @(negedge clk);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0100_041C) begin
      err_cnt++;
      $display("FAIL make_code: got %h want %h", bus.keyboard_data, 32'h0100_041C);
    end
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arrow();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0100_1575) begin
      err_cnt++;
      $display("FAIL arrow_make: got %h want %h", bus.keyboard_data, 32'h0100_1575);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0200_0775) begin
      err_cnt++;
      $display("FAIL arrow_break: got %h want %h", bus.keyboard_data, 32'h0200_0775);
    end
  endtask

  task automatic test_ack_collision();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk) bus.ack = 1'b0;
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0300_041C) begin
      err_cnt++;
      $display("FAIL ack_collision: got %h want %h", bus.keyboard_data, 32'h0300_041C);
    end
    repeat (half) @(negedge clk);
    bus.ps2_clk = 1'b1;
    pulse_ack();
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0300_001C) begin
      err_cnt++;
      $display("FAIL ack_alone: got %h want %h", bus.keyboard_data, 32'h0300_001C);
    end
  endtask

  task automatic test_parity_error();
    logic [31:0] exp_err, exp_ack;
`ifdef PS2_PARITY_CHECK_EN
    exp_err = 32'h0300_081C;
    exp_ack = 32'h0300_001C;
    base    = 8'h03;
`else
    exp_err = 32'h0400_041C;
    exp_ack = 32'h0400_001C;
    base    = 8'h04;
`endif
    send_frame(frame(8'h1C, 1'b1, 1'b1));
    vec_cnt++;
    if (bus.keyboard_data !== exp_err) begin
      err_cnt++;
      $display("FAIL parity_frame: got %h want %h", bus.keyboard_data, exp_err);
    end
    pulse_ack();
    vec_cnt++;
    if (bus.keyboard_data !== exp_ack) begin
      err_cnt++;
      $display("FAIL parity_ack: got %h want %h", bus.keyboard_data, exp_ack);
    end
  endtask

  task automatic test_stop_error();
    send_frame(frame(8'h1C, 1'b0, 1'b0));
    vec_cnt++;
    if (bus.keyboard_data !== {base, 24'h00081C}) begin
      err_cnt++;
      $display("FAIL stop_error: got %h want %h", bus.keyboard_data, {base, 24'h00081C});
    end
    pulse_ack();
    vec_cnt++;
    if (bus.keyboard_data !== {base, 24'h00001C}) begin
      err_cnt++;
      $display("FAIL stop_ack: got %h want %h", bus.keyboard_data, {base, 24'h00001C});
    end
  endtask

  // Pending E0, then a stalled partial frame; the timeout must drop both
  task automatic test_timeout();
    send_byte(8'hE0);
    send_bits(11'h00A, 4);
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (TIMEOUT + 20) @(negedge clk);
    vec_cnt++;
    if (bus.keyboard_data !== {base, 24'h00001C}) begin
      err_cnt++;
      $display("FAIL timeout_quiet: got %h want %h", bus.keyboard_data, {base, 24'h00001C});
    end
    send_byte(8'h29);
    vec_cnt++;
    if (bus.keyboard_data !== {base + 8'd1, 24'h010429}) begin
      err_cnt++;
      $display("FAIL timeout_space: got %h want %h", bus.keyboard_data,
               {base + 8'd1, 24'h010429});
    end
    send_byte(8'hF0);
    send_byte(8'h29);
    vec_cnt++;
    if (bus.keyboard_data !== {base + 8'd2, 24'h000629}) begin
      err_cnt++;
      $display("FAIL space_break: got %h want %h", bus.keyboard_data,
               {base + 8'd2, 24'h000629});
    end
  endtask

  task automatic test_counter_wrap();
    half = 4;
    do_reset();
    for (int i = 0; i < 255; i++) send_byte(8'h1C);
    vec_cnt++;
    if (bus.keyboard_data !== 32'hFF00_041C) begin
      err_cnt++;
      $display("FAIL count_255: got %h want %h", bus.keyboard_data, 32'hFF00_041C);
    end
    send_byte(8'h1C);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0000_041C) begin
      err_cnt++;
      $display("FAIL count_wrap: got %h want %h", bus.keyboard_data, 32'h0000_041C);
    end
    half = 20;
  endtask

  task automatic test_reset_mid_frame();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 6);
    @(negedge clk) reset = 1'b1;
    #1;
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid: got %h want %h", bus.keyboard_data, 32'h0);
    end
    bus.ps2_data = 1'b1;
    bus.ps2_clk  = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h1C);
    vec_cnt++;
    if (bus.keyboard_data !== 32'h0100_041C) begin
      err_cnt++;
      $display("FAIL reset_resync: got %h want %h", bus.keyboard_data, 32'h0100_041C);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.ack      = 1'b0;
    base         = 8'h00;
    test_reset();
    test_make_code();
    test_arrow();
    test_ack_collision();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_counter_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
